ads_ram_arbiter: RTL and testbench

- Shares the single-port 32-bit sample RAM (DEPTH words, 14-bit word address, byte enables, one-cycle read latency) between two requesters:
  - the ADS131A0X capture stream, which writes samples into a ring buffer;
  - an Avalon-MM host port, which reads and writes random addresses.
- Sits between the capture/deframer logic and the RAM macro.
- Tracks the ring write pointer, fill count and overflow for software.

---
 rtl/ads_ram_arbiter_if.sv | 24 ++
 rtl/ads_ram_arbiter.sv | 127 ++++++++++++
 tb/tb_ads_ram_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ads_ram_arbiter_if.sv
// Avalon-MM style host port into the sample-RAM arbiter.
// The host drives master; the arbiter takes the slave side.
interface ads_ram_arbiter_if #(
    parameter int unsigned AW = 14
) ();
    logic [AW-1:0] address;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic [3:0]    byteenable;
    logic          waitrequest;
    logic [31:0]   readdata;
    logic          readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/ads_ram_arbiter.sv
// Shares the single-port sample RAM between the ADS131A0X capture ring and an Avalon-MM host.
// Define ADS_RAM_ARB_FIXED_PRIO_EN to give capture fixed priority instead of round-robin.
module ads_ram_arbiter #(
    parameter int unsigned DEPTH = 10240,
    parameter int unsigned AW    = 14,
    parameter int unsigned CW    = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                cap_valid,
    input  logic [31:0]         cap_data,
    output logic                cap_ready,
    ads_ram_arbiter_if.slave    host,
    output logic [AW-1:0]       ram_address,
    output logic [3:0]          ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [31:0]         ram_writedata,
    output logic                ram_clken,
    input  logic [31:0]         ram_readdata,
    output logic [AW-1:0]       wr_ptr,
    output logic [CW-1:0]       fill_count,
    output logic                overflow
);
    localparam logic [AW-1:0] LastAddr  = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    logic          host_req;
    logic          cap_req;
    logic          cap_grant;
    logic          host_grant;
    logic          rd_pend;
    logic [AW-1:0] addr_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;

`ifdef ADS_RAM_ARB_FIXED_PRIO_EN
    always_comb begin
        host_req   = host.read | host.write;
        cap_req    = cap_valid & ~clear;
        cap_grant  = cap_req;
        host_grant = host_req & ~cap_grant;
    end
`else
    // last_grant: 0 = capture won the last granted cycle, 1 = host did.
    logic last_grant;

    always_comb begin
        host_req   = host.read | host.write;
        cap_req    = cap_valid & ~clear;
        cap_grant  = cap_req & (~host_req | last_grant);
        host_grant = host_req & ~cap_grant;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b0;
        end else if (cap_grant | host_grant) begin
            last_grant <= host_grant;
        end
    end
`endif

    // Address/data/byte enables hold their last value on idle cycles.
    always_comb begin
        cap_ready        = cap_grant;
        host.waitrequest = host_req & ~host_grant;
        ram_chipselect   = cap_grant | host_grant;
        ram_write        = cap_grant | (host_grant & host.write);
        ram_clken        = 1'b1;
        ram_address      = addr_q;
        ram_byteenable   = be_q;
        ram_writedata    = wdata_q;
        if (cap_grant) begin
            ram_address    = wr_ptr;
            ram_byteenable = 4'hF;
            ram_writedata  = cap_data;
        end else if (host_grant) begin
            ram_address    = host.address;
            ram_byteenable = host.byteenable;
            ram_writedata  = host.writedata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q             <= '0;
            be_q               <= '0;
            wdata_q            <= '0;
            rd_pend            <= 1'b0;
            host.readdatavalid <= 1'b0;
            host.readdata      <= '0;
        end else begin
            if (cap_grant | host_grant) begin
                addr_q  <= ram_address;
                be_q    <= ram_byteenable;
                wdata_q <= ram_writedata;
            end
            // A simultaneous read+write is treated as a write only.
            rd_pend            <= host_grant & host.read & ~host.write;
            host.readdatavalid <= rd_pend;
            if (rd_pend) begin
                host.readdata <= ram_readdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            fill_count <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            fill_count <= '0;
            overflow   <= 1'b0;
        end else if (cap_grant) begin
            wr_ptr <= (wr_ptr == LastAddr) ? '0 : wr_ptr + 1'b1;
            if (fill_count < FullCount) begin
                fill_count <= fill_count + 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ads_ram_arbiter.sv
// Randomised self-checking bench for ads_ram_arbiter against a cycle-level reference model.
// Honours ADS_RAM_ARB_FIXED_PRIO_EN the same way the design does.
module tb_ads_ram_arbiter;
    localparam int unsigned DEPTH = 10240;
    localparam int unsigned AW    = 14;
    localparam int unsigned CW    = 15;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear;
    logic          cap_valid;
    logic [31:0]   cap_data;
    logic          cap_ready;
    logic [AW-1:0] ram_address;
    logic [3:0]    ram_byteenable;
    logic          ram_chipselect;
    logic          ram_write;
    logic [31:0]   ram_writedata;
    logic          ram_clken;
    logic [31:0]   ram_readdata;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] fill_count;
    logic          overflow;

    ads_ram_arbiter_if #(.AW(AW)) host ();

    always #5 clk = ~clk;

    ads_ram_arbiter #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear          (clear),
        .cap_valid      (cap_valid),
        .cap_data       (cap_data),
        .cap_ready      (cap_ready),
        .host           (host.slave),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata),
        .wr_ptr         (wr_ptr),
        .fill_count     (fill_count),
        .overflow       (overflow)
    );

    // RAM macro: byte-enabled writes, one-cycle read latency.
    logic [31:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end else begin
                ram_readdata <= ram_mem[ram_address];
            end
        end
    end

    // Reference model state
    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    logic [31:0] ref_mem [DEPTH];
    rd_t         rq [$];
    int          m_wr_ptr;
    int          m_fill;
    bit          m_ovf;
    bit          m_last_host;
    int          m_addr;
    int          cyc;
    int          errors;
    int          checks;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic cycle(input logic cv, input logic [31:0] cd, input logic hr, input logic hw,
                         input logic [AW-1:0] ha, input logic [31:0] hd, input logic [3:0] hb,
                         input logic clr);
        bit cg, hg, creq, hreq, exp_v;
        cap_valid          = cv;
        cap_data           = cd;
        host.read          = hr;
        host.write         = hw;
        host.address       = ha;
        host.writedata     = hd;
        host.byteenable    = hb;
        clear              = clr;
        @(negedge clk);
        hreq = hr | hw;
        creq = cv & !clr;
`ifdef ADS_RAM_ARB_FIXED_PRIO_EN
        cg = creq;
`else
        // Contention goes to whoever was not granted last.
        if (creq && hreq) cg = m_last_host;
        else              cg = creq;
`endif
        hg = hreq && !cg;
        check_eq("cap_ready", cap_ready, cg);
        check_eq("waitrequest", host.waitrequest, hreq && !hg);
        check_eq("chipselect", ram_chipselect, cg || hg);
        check_eq("ram_write", ram_write, cg || (hg && hw));
        check_eq("clken", ram_clken, 1'b1);
        if (cg) begin
            check_eq("cap_addr", ram_address, m_wr_ptr);
            check_eq("cap_be", ram_byteenable, 4'hF);
            check_eq("cap_wdata", ram_writedata, cd);
        end else if (hg) begin
            check_eq("host_addr", ram_address, ha);
            check_eq("host_be", ram_byteenable, hb);
            if (hw) check_eq("host_wdata", ram_writedata, hd);
        end else begin
            check_eq("idle_addr_hold", ram_address, m_addr);
        end
        check_eq("wr_ptr", wr_ptr, m_wr_ptr);
        check_eq("fill_count", fill_count, m_fill);
        check_eq("overflow", overflow, m_ovf);
        exp_v = (rq.size() > 0) && (rq[0].due == cyc);
        check_eq("readdatavalid", host.readdatavalid, exp_v);
        if (exp_v) begin
            check_eq("readdata", host.readdata, rq[0].data);
            void'(rq.pop_front());
        end
        @(posedge clk);
        cyc++;
        if (cg) begin
            ref_mem[m_wr_ptr] = cd;
            m_addr   = m_wr_ptr;
            m_wr_ptr = (m_wr_ptr + 1) % DEPTH;
            if (m_fill < DEPTH) m_fill++;
            else                m_ovf = 1'b1;
        end else if (hg) begin
            m_addr = ha;
            if (hw) begin
                for (int b = 0; b < 4; b++)
                    if (hb[b]) ref_mem[ha][8*b +: 8] = hd[8*b +: 8];
            end else begin
                rq.push_back('{due: cyc + 1, data: ref_mem[ha]});
            end
        end
        if (clr) begin
            m_wr_ptr = 0;
            m_fill   = 0;
            m_ovf    = 1'b0;
        end
        if (cg || hg) m_last_host = hg;
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0, 4'h0, 1'b0);
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0;
        m_wr_ptr = 0; m_fill = 0; m_ovf = 1'b0; m_last_host = 1'b0; m_addr = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        reset_n = 1'b0; clear = 1'b0; cap_valid = 1'b0; cap_data = '0;
        host.read = 1'b0; host.write = 1'b0; host.address = '0;
        host.writedata = '0; host.byteenable = '0;
        #13;
        check_eq("rst_wr_ptr", wr_ptr, 0);
        check_eq("rst_fill", fill_count, 0);
        check_eq("rst_overflow", overflow, 1'b0);
        check_eq("rst_rdvalid", host.readdatavalid, 1'b0);
        check_eq("rst_readdata", host.readdata, 32'h0);
        check_eq("rst_chipselect", ram_chipselect, 1'b0);
        check_eq("rst_ram_write", ram_write, 1'b0);
        @(posedge clk);
        reset_n = 1'b1;
        #1;

        // Three capture words with the host idle
        for (int i = 1; i <= 3; i++) cycle(1'b1, 32'hA000_0000 + i, 1'b0, 1'b0, '0, 0, 4'h0, 1'b0);
        idle();
        check_eq("ring_word0", ram_mem[0], 32'hA000_0001);
        check_eq("ring_word2", ram_mem[2], 32'hA000_0003);

        // Capture and host read contending for four cycles
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'hC0DE_0000 + i, 1'b1, 1'b0, AW'(i), 0, 4'hF, 1'b0);
        idle(); idle();

        // Byte-enabled host write merge, then read back
        cycle(1'b0, 0, 1'b0, 1'b1, AW'(5), 32'h1122_3344, 4'hF, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b1, AW'(5), 32'hDEAD_BEEF, 4'b0011, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0, AW'(5), 0, 4'hF, 1'b0);
        idle(); idle();
        check_eq("be_merge", ram_mem[5], 32'h1122_BEEF);

        // clear alongside cap_valid, then capture again
        cycle(1'b1, 32'h5555_0000, 1'b0, 1'b0, '0, 0, 4'h0, 1'b1);
        cycle(1'b1, 32'h5555_0001, 1'b0, 1'b0, '0, 0, 4'h0, 1'b0);
        idle();

`ifdef ADS_RAM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 32'hF1F0_0000 + i, 1'b1, 1'b0, AW'(7), 0, 4'hF, 1'b0);
        end
        cycle(1'b0, 0, 1'b1, 1'b0, AW'(7), 0, 4'hF, 1'b0);
        idle(); idle();
`endif

        // Randomised mix
        for (int i = 0; i < 3000; i++) begin
            logic cv, hr, hw, clr;
            int   op;
            op  = $urandom_range(99);
            cv  = $urandom_range(1);
            hr  = (op < 40) || (op >= 95);
            hw  = (op >= 40 && op < 75) || (op >= 95);
            clr = ($urandom_range(99) < 3);
            cycle(cv, $urandom, hr, hw, AW'($urandom_range(DEPTH - 1)), $urandom,
                  4'($urandom), clr);
        end
        idle(); idle();

        // Fill to DEPTH, overflow, and wrap from the last address
        cycle(1'b0, 0, 1'b0, 1'b0, '0, 0, 4'h0, 1'b1);
        for (int i = 0; i < 2 * DEPTH; i++)
            cycle(1'b1, 32'h7000_0000 + i, 1'b0, 1'b0, '0, 0, 4'h0, 1'b0);
        idle();
        check_eq("wrap_last_word", ram_mem[DEPTH - 1], 32'h7000_0000 + 2 * DEPTH - 1);
        check_eq("wrap_ptr", wr_ptr, 0);
        check_eq("full_fill", fill_count, DEPTH);
        check_eq("full_overflow", overflow, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
